ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Controller that runs the 64 x 8 single-port RAM as a 64-entry byte FIFO. It sits directly upstream of the RAM and drives its `data`, `addr` and `we` inputs, issuing at most one RAM operation per cycle. It consumes the RAM's `out` port, which is combinational from the address registered on a `we=0` cycle. A push/pop handshake faces the producer and consumer logic.

## Interface
- `DATA_W`, 8: byte width; must match RAM data width.
- `ADDR_W`, 6: RAM address width; depth = 2^ADDR_W = 64.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  producer has a byte.
- `push_data`  in  DATA_W  byte to store.
- `push_ready`  out  1  push accepted this cycle when `push_valid && push_ready`.
- `pop_req`  in  1  consumer requests one byte.
- `pop_ready`  out  1  pop granted this cycle when `pop_req && pop_ready`.
- `pop_valid`  out  1  one-cycle strobe: `pop_data` holds a popped byte.
- `pop_data`  out  DATA_W  popped byte; held until the next `pop_valid`.
- `count`  out  ADDR_W+1  occupancy, 0..64.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == 64`.
- `ram_data`  out  DATA_W  to RAM `data`; always equals `push_data`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_we`  out  1  to RAM `we`.
- `ram_out`  in  DATA_W  from RAM `out`.

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDR_W bits each, wrap 63 -> 0), `count`, `prio` (last-grant flag), 2-stage pop pipeline (`rd_pend`, `pop_valid`).
- Eligibility: push eligible = `push_valid && !full`; pop eligible = `pop_req && !empty`.
- Arbitration, one grant per cycle:
  - Only one side eligible: that side wins.
  - Both eligible: side opposite `prio` wins. `prio` records the last winner and updates only on contested cycles.
  - After reset, the first contested cycle goes to pop.
- `pop_ready = pop_req && !empty && (!push_valid || full || prio == PUSH)`.
- `push_ready = !full && !(pop_ready && pop_req)`.
- `push_ready` may depend combinationally on `push_valid`/`pop_req`. Neither ready signal may combinationally feed back into a valid or request input.
- Push grant: `ram_we=1`, `ram_addr=wr_ptr`. At the edge, `wr_ptr` increments and `count` increments.
- Pop grant: `ram_we=0`, `ram_addr=rd_ptr`, so the RAM latches the read address. At the edge, `rd_ptr` increments, `count` decrements and `rd_pend` is set.
- Idle cycle: `ram_we=0`, `ram_addr=rd_ptr`. This harmlessly reloads the RAM read address.
- Capture: in the cycle after a pop grant (`rd_pend=1`), `ram_out` is registered into `pop_data` at the edge, and `pop_valid` goes high for the following cycle.
- Push and pop grants never occur in the same cycle, so `count` changes by at most 1 per cycle.

## Timing
- Pop latency: grant in cycle N, RAM address latched at end of N, `ram_out` valid in N+1, `pop_valid`/`pop_data` in N+2.
- Back-to-back pops are allowed: one `pop_valid` per cycle, in grant order.
- Push in N makes the entry poppable in N+1 (`empty` deasserts in N+1); the write completes at end of N.
- Pop granted in N frees its slot in N+1, so `full` deasserts in N+1.
- Wrap-around / full boundary: when the FIFO is full, a pop in N followed by a push in N+1 targets the same RAM location.
  - The capture at end of N+1 samples the pre-write value. Required: `pop_data` = old byte.
  - A push-cycle write does not change the RAM's latched read address, so the in-flight read is unaffected.
- `full`: `push_ready=0`; a pop is granted regardless of `prio`.
- `empty`: `pop_ready=0`; a push is granted regardless of `prio`.
- Reset values, asserted while `rst=1` and in the cycle after it is sampled:
  - `wr_ptr=rd_ptr=0`, `count=0`, `empty=1`, `full=0`.
  - `pop_valid=0`, `pop_data=0`, `rd_pend=0`, `prio` = "last was push".
  - `ram_we=0`, `push_ready=0`, `pop_ready=0`.
- Reset mid-operation: an in-flight pop is discarded, with no `pop_valid` after reset. RAM contents are not cleared; they are unreachable because pointers reset.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> `ram_we=1` at addr 0, 1, 2; `count=3`; `empty=0` one cycle after the first push.
- Pop 3 back-to-back from that state -> `pop_valid` in cycles grant+2 for three cycles with 0x11, 0x22, 0x33; `count=0`, `empty=1`.
- Push 64 bytes 0x00..0x3F -> `full=1`, `push_ready=0` with `push_valid` held high. Then pop in N and push 0xAA in N+1 -> popped byte is 0x00; `wr_ptr` wraps to 1 after 0xAA is written at addr 0.
- Hold `push_valid` and `pop_req` high with `count=10` -> grants alternate pop, push, pop, push starting with pop; `count` oscillates 9/10.
- Fill 70 and drain 70 with continuous requests -> 64 accepted; `pop_data` sequence matches push order across the wrap.
- Assert `rst` in the cycle after a pop grant -> no `pop_valid` appears; `count=0`, `empty=1`; the next push lands at addr 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller driving an external 64 x 8 single-port RAM.
// Push and pop share the one RAM port; a round-robin flag settles contested cycles.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic {
        PRIO_POP  = 1'b0,
        PRIO_PUSH = 1'b1
    } prio_t;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    prio_t             prio;
    logic              rd_pend;

    logic push_elig;
    logic pop_elig;
    logic push_grant;
    logic pop_grant;
    logic contested;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        empty      = 1'b0;
        full       = 1'b0;
        push_elig  = 1'b0;
        pop_elig   = 1'b0;
        pop_ready  = 1'b0;
        push_ready = 1'b0;
        push_grant = 1'b0;
        pop_grant  = 1'b0;
        contested  = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = rd_ptr;
        ram_data   = push_data;

        empty     = (count == '0);
        full      = (count == FULL_CNT);
        push_elig = push_valid && !full;
        pop_elig  = pop_req && !empty;
        contested = push_elig && pop_elig;

        // Pop wins when push is absent, blocked by full, or had the last contested grant.
        if (!rst) begin
            pop_ready  = pop_elig && (!push_valid || full || prio == PRIO_PUSH);
            push_ready = !full && !(pop_ready && pop_req);
        end

        push_grant = push_valid && push_ready;
        pop_grant  = pop_req && pop_ready;

        // Idle and pop cycles both present rd_ptr, so the RAM always holds the next read address.
        if (push_grant) begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= PRIO_PUSH;
            rd_pend   <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            if (push_grant) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_grant) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push_grant, pop_grant})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (contested) begin
                prio <= pop_grant ? PRIO_POP : PRIO_PUSH;
            end

            // ram_out reflects the address latched at the grant edge, even if a write follows.
            rd_pend   <= pop_grant;
            pop_valid <= rd_pend;
            if (rd_pend) begin
                pop_data <= ram_out;
            end
        end
    end

    a_one_grant : assert property (@(posedge clk) disable iff (rst)
        !(push_grant && pop_grant));

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        count <= FULL_CNT);

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        full |-> !push_ready);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 64 x 8 single-port RAM attached.
module tb_ram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_req    (pop_req),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_out    (ram_out)
    );

    // RAM: write on we, otherwise latch the read address; out reads the latched address.
    logic [DATA_W-1:0] mem [64];
    logic [ADDR_W-1:0] addr_q;
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else        addr_q        <= ram_addr;
    end
    assign ram_out = mem[addr_q];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push_valid = 1'b0; pop_req = 1'b0; push_data = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push_valid = 1'b1; pop_req = 1'b1; push_data = 8'h5A;
        repeat (3) next_cycle();
        #1;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b exp 0", pop_valid); end
        checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data: got %h exp 00", pop_data); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b exp 0", ram_we); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL reset_push_ready: got %b exp 0", push_ready); end
        checks++; if (pop_ready !== 1'b0) begin errors++; $display("FAIL reset_pop_ready: got %b exp 0", pop_ready); end
        rst = 1'b0; push_valid = 1'b0; pop_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_push3();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = vals[i];
            #1;
            checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL push3_we[%0d]: got %b exp 1", i, ram_we); end
            checks++; if (ram_addr !== 6'(i)) begin errors++; $display("FAIL push3_addr[%0d]: got %0d exp %0d", i, ram_addr, i); end
            checks++; if (ram_data !== vals[i]) begin errors++; $display("FAIL push3_data[%0d]: got %h exp %h", i, ram_data, vals[i]); end
            checks++; if (empty !== (i == 0)) begin errors++; $display("FAIL push3_empty[%0d]: got %b exp %b", i, empty, i == 0); end
            next_cycle();
        end
        push_valid = 1'b0;
        #1;
        checks++; if (count !== 7'd3) begin errors++; $display("FAIL push3_count: got %0d exp 3", count); end
    endtask

    task automatic test_pop3();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int k = 0; k < 6; k++) begin
            pop_req = (k < 3);
            #1;
            if (k < 3) begin
                checks++; if (pop_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 6'(k)) begin
                    errors++; $display("FAIL pop3_grant[%0d]: got rdy=%b we=%b addr=%0d exp rdy=1 we=0 addr=%0d", k, pop_ready, ram_we, ram_addr, k);
                end
            end
            checks++; if (pop_valid !== (k >= 2 && k < 5)) begin errors++; $display("FAIL pop3_valid[%0d]: got %b exp %b", k, pop_valid, k >= 2 && k < 5); end
            if (k >= 2 && k < 5) begin
                checks++; if (pop_data !== vals[k-2]) begin errors++; $display("FAIL pop3_data[%0d]: got %h exp %h", k, pop_data, vals[k-2]); end
            end
            checks++; if (count !== 7'((k < 3) ? 3 - k : 0)) begin errors++; $display("FAIL pop3_count[%0d]: got %0d exp %0d", k, count, (k < 3) ? 3 - k : 0); end
            next_cycle();
        end
        pop_req = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop3_empty: got %b exp 1", empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            #1;
            checks++; if (ram_we !== 1'b1 || ram_addr !== 6'(i)) begin errors++; $display("FAIL fill_write[%0d]: got we=%b addr=%0d exp we=1 addr=%0d", i, ram_we, ram_addr, i); end
            next_cycle();
        end
        push_data = 8'hEE;
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b exp 1", full); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready: got %b exp 0", push_ready); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_ram_we: got %b exp 0", ram_we); end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL full_count: got %0d exp 64", count); end
        pop_req = 1'b1;
        #1;
        checks++; if (pop_ready !== 1'b1 || ram_addr !== 6'd0) begin errors++; $display("FAIL wrap_pop: got rdy=%b addr=%0d exp rdy=1 addr=0", pop_ready, ram_addr); end
        next_cycle();
        pop_req = 1'b0; push_data = 8'hAA;
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full_drop: got %b exp 0", full); end
        checks++; if (push_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd0) begin errors++; $display("FAIL wrap_push: got rdy=%b we=%b addr=%0d exp 1 1 0", push_ready, ram_we, ram_addr); end
        next_cycle();
        push_valid = 1'b0;
        #1;
        checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL wrap_pop_valid: got %b exp 1", pop_valid); end
        checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL wrap_pop_data: got %h exp 00", pop_data); end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL wrap_count: got %0d exp 64", count); end
        checks++; if (dut.wr_ptr !== 6'd1) begin errors++; $display("FAIL wrap_wr_ptr: got %0d exp 1", dut.wr_ptr); end
        next_cycle();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_valid = 1'b1; push_data = 8'(8'h80 + i);
            next_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            push_valid = (k < 8); pop_req = (k < 8); push_data = 8'(8'hC0 + k);
            #1;
            if (k < 8) begin
                checks++; if (pop_ready !== (k % 2 == 0) || ram_we !== (k % 2 == 1)) begin
                    errors++; $display("FAIL alt_grant[%0d]: got pop=%b we=%b exp pop=%b we=%b", k, pop_ready, ram_we, k % 2 == 0, k % 2 == 1);
                end
            end
            checks++; if (count !== 7'((k < 8 && k % 2 == 1) ? 9 : 10)) begin errors++; $display("FAIL alt_count[%0d]: got %0d exp %0d", k, count, (k < 8 && k % 2 == 1) ? 9 : 10); end
            checks++; if (pop_valid !== (k >= 2 && k <= 8 && k % 2 == 0)) begin errors++; $display("FAIL alt_pop_valid[%0d]: got %b", k, pop_valid); end
            if (k >= 2 && k <= 8 && k % 2 == 0) begin
                checks++; if (pop_data !== 8'(8'h80 + k / 2 - 1)) begin errors++; $display("FAIL alt_pop_data[%0d]: got %h exp %h", k, pop_data, 8'(8'h80 + k / 2 - 1)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_q [$] = '{8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'hC1, 8'hC3, 8'hC5, 8'hC7};
        logic [7:0] got [$];
        int accepted = 0;
        for (int c = 0; c < 12; c++) begin
            pop_req = (c < 10);
            #1;
            if (pop_valid) got.push_back(pop_data);
            next_cycle();
        end
        pop_req = 1'b0;
        checks++; if (got.size() != 10) begin errors++; $display("FAIL drain10_size: got %0d exp 10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL drain10_data[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
        end
        got.delete();
        for (int i = 0; i < 70; i++) begin
            push_valid = 1'b1; push_data = 8'(i + 1);
            #1;
            if (push_ready) accepted++;
            next_cycle();
        end
        push_valid = 1'b0;
        #1;
        checks++; if (accepted != 64) begin errors++; $display("FAIL fill70_accepted: got %0d exp 64", accepted); end
        checks++; if (full !== 1'b1 || count !== 7'd64) begin errors++; $display("FAIL fill70_full: got full=%b count=%0d exp 1 64", full, count); end
        for (int c = 0; c < 72; c++) begin
            pop_req = (c < 70);
            #1;
            if (pop_valid) got.push_back(pop_data);
            next_cycle();
        end
        pop_req = 1'b0;
        checks++; if (got.size() != 64) begin errors++; $display("FAIL drain70_size: got %0d exp 64", got.size()); end
        for (int i = 0; i < 64 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL drain70_data[%0d]: got %h exp %h", i, got[i], 8'(i + 1)); end
        end
        checks++; if (empty !== 1'b1 || count !== 7'd0) begin errors++; $display("FAIL drain70_empty: got empty=%b count=%0d exp 1 0", empty, count); end
    endtask

    task automatic test_reset_midpop();
        for (int i = 0; i < 2; i++) begin
            push_valid = 1'b1; push_data = 8'(8'hD0 + i);
            next_cycle();
        end
        push_valid = 1'b0; pop_req = 1'b1;
        #1;
        checks++; if (pop_ready !== 1'b1) begin errors++; $display("FAIL midrst_pop_grant: got %b exp 1", pop_ready); end
        next_cycle();
        pop_req = 1'b0; rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL midrst_pop_valid[%0d]: got %b exp 0", c, pop_valid); end
            next_cycle();
            rst = 1'b0;
        end
        checks++; if (count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL midrst_state: got count=%0d empty=%b exp 0 1", count, empty); end
        push_valid = 1'b1; push_data = 8'h77;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 6'd0) begin errors++; $display("FAIL midrst_push_addr: got we=%b addr=%0d exp 1 0", ram_we, ram_addr); end
        next_cycle();
        push_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; pop_req = 1'b0; push_data = '0;
        next_cycle();
        test_reset();
        test_push3();
        test_pop3();
        test_full_wrap();
        test_alternate();
        test_fill_drain();
        test_reset_midpop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
